// File: rtl/mem_access_ctrl_if.sv
// Bus bundle between the MEM stage, the access controller and the board pins.
//   CPU side : mem_read_i / mem_write_i / addr_i / wdata_i in, rdata_o / busy_o / done_o out
//   RAM1     : en/oe/we (active-low), addr, dout/doe/din (shared with UART data)
//   RAM2     : en/oe/we (active-low), addr, dout/doe/din
//   UART     : rdn/wrn strobes (active-low), data_ready/tbre/tsre status in
// slave  = controller view, master = pipeline + board view.
interface mem_access_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              mem_read_i, mem_write_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i, rdata_o;
  logic              busy_o, done_o;
  logic              ram1_en, ram1_oe, ram1_we, ram1_doe;
  logic [ADDR_W-1:0] ram1_addr;
  logic [DATA_W-1:0] ram1_dout, ram1_din;
  logic              ram2_en, ram2_oe, ram2_we, ram2_doe;
  logic [ADDR_W-1:0] ram2_addr;
  logic [DATA_W-1:0] ram2_dout, ram2_din;
  logic              uart_rdn, uart_wrn;
  logic              uart_data_ready, uart_tbre, uart_tsre;

  modport slave (
    input  mem_read_i, mem_write_i, addr_i, wdata_i,
    output rdata_o, busy_o, done_o,
    output ram1_en, ram1_oe, ram1_we, ram1_addr, ram1_dout, ram1_doe,
    input  ram1_din,
    output ram2_en, ram2_oe, ram2_we, ram2_addr, ram2_dout, ram2_doe,
    input  ram2_din,
    output uart_rdn, uart_wrn,
    input  uart_data_ready, uart_tbre, uart_tsre
  );

  modport master (
    output mem_read_i, mem_write_i, addr_i, wdata_i,
    input  rdata_o, busy_o, done_o,
    input  ram1_en, ram1_oe, ram1_we, ram1_addr, ram1_dout, ram1_doe,
    output ram1_din,
    input  ram2_en, ram2_oe, ram2_we, ram2_addr, ram2_dout, ram2_doe,
    output ram2_din,
    input  uart_rdn, uart_wrn,
    output uart_data_ready, uart_tbre, uart_tsre
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage memory access controller.
// Decodes the access address to RAM2 (low space), UART data/status registers
// or RAM1 (high space), runs a SETUP / STROBE(WAIT_CYC) / DONE strobe sequence
// and stalls the pipeline with busy_o until the access completes.
// Ports: clk, rst (async, active-high), bus (mem_access_ctrl_if.slave).
module mem_access_ctrl #(
  parameter int                DATA_W         = 16,
  parameter int                ADDR_W         = 16,
  parameter logic [ADDR_W-1:0] RAM2_TOP       = 16'hBEFF,
  parameter logic [ADDR_W-1:0] UART_DATA_ADDR = 16'hBF00,
  parameter logic [ADDR_W-1:0] UART_STAT_ADDR = 16'hBF01,
  parameter int                WAIT_CYC       = 1
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_DONE} state_e;
  typedef enum logic [1:0] {T_RAM1, T_RAM2, T_UDATA, T_USTAT} tgt_e;

  localparam logic [2:0] LAST_CNT = 3'(WAIT_CYC - 1);

  state_e            state_q, state_d;
  tgt_e              tgt_q, tgt_d, tgt_dec;
  logic              wr_q, wr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [ADDR_W-1:0] ram1_addr_q, ram1_addr_d, ram2_addr_q, ram2_addr_d;
  logic              req_ok, active, strobe;

  // Exactly one of read/write makes a valid request.
  assign req_ok = bus.mem_read_i ^ bus.mem_write_i;

  always_comb begin
    if (bus.addr_i <= RAM2_TOP)             tgt_dec = T_RAM2;
    else if (bus.addr_i == UART_DATA_ADDR)  tgt_dec = T_UDATA;
    else if (bus.addr_i == UART_STAT_ADDR)  tgt_dec = T_USTAT;
    else                                    tgt_dec = T_RAM1;
  end

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    ram1_addr_d = ram1_addr_q;
    ram2_addr_d = ram2_addr_q;
    case (state_q)
      S_IDLE: if (req_ok) begin
        tgt_d   = tgt_dec;
        wr_d    = bus.mem_write_i;
        wdata_d = bus.wdata_i;
        if (tgt_dec == T_RAM1) ram1_addr_d = bus.addr_i;
        if (tgt_dec == T_RAM2) ram2_addr_d = bus.addr_i;
        if (tgt_dec == T_USTAT) begin
          // Status register needs no bus cycle; writes to it are dropped.
          state_d = S_DONE;
          if (!bus.mem_write_i) begin
            rdata_d    = '0;
            rdata_d[1] = bus.uart_data_ready;
            rdata_d[0] = bus.uart_tbre & bus.uart_tsre;
          end
        end else begin
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_STROBE;
      end
      S_STROBE: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
          // UART data shares the RAM1 bus.
          if (!wr_q) rdata_d = (tgt_q == T_RAM2) ? bus.ram2_din : bus.ram1_din;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tgt_q       <= T_RAM1;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      ram1_addr_q <= '0;
      ram2_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      ram1_addr_q <= ram1_addr_d;
      ram2_addr_q <= ram2_addr_d;
    end
  end

  // Strobes decode straight from registered state, so reset forces them high at once.
  assign active = (state_q == S_SETUP) || (state_q == S_STROBE);
  assign strobe = (state_q == S_STROBE);

  assign bus.ram1_en   = !(active && tgt_q == T_RAM1);
  assign bus.ram1_oe   = !(strobe && tgt_q == T_RAM1 && !wr_q);
  assign bus.ram1_we   = !(strobe && tgt_q == T_RAM1 &&  wr_q);
  assign bus.ram2_en   = !(active && tgt_q == T_RAM2);
  assign bus.ram2_oe   = !(strobe && tgt_q == T_RAM2 && !wr_q);
  assign bus.ram2_we   = !(strobe && tgt_q == T_RAM2 &&  wr_q);
  assign bus.uart_rdn  = !(strobe && tgt_q == T_UDATA && !wr_q);
  assign bus.uart_wrn  = !(strobe && tgt_q == T_UDATA &&  wr_q);
  // Drive only on writes, so a bus is never driven while its read strobe is low.
  assign bus.ram1_doe  = active && wr_q && (tgt_q == T_RAM1 || tgt_q == T_UDATA);
  assign bus.ram2_doe  = active && wr_q && (tgt_q == T_RAM2);
  assign bus.ram1_dout = wdata_q;
  assign bus.ram2_dout = wdata_q;
  assign bus.ram1_addr = ram1_addr_q;
  assign bus.ram2_addr = ram2_addr_q;
  assign bus.rdata_o   = rdata_q;
  assign bus.done_o    = (state_q == S_DONE);
  assign bus.busy_o    = ((state_q == S_IDLE) && req_ok) || active;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench: one DUT with WAIT_CYC=1 (b1/dut1), one with WAIT_CYC=3 (b3/dut3).
// Inputs change at/after the falling edge; outputs are sampled there too.
module tb_mem_access_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec = 0;
  int   err = 0;

  always #5 clk = ~clk;

  mem_access_ctrl_if b1();
  mem_access_ctrl_if b3();

  mem_access_ctrl #(.WAIT_CYC(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  mem_access_ctrl #(.WAIT_CYC(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  // {ram1_en, ram1_oe, ram1_we, ram2_en, ram2_oe, ram2_we, uart_rdn, uart_wrn}
  function automatic logic [7:0] stb1();
    return {b1.ram1_en, b1.ram1_oe, b1.ram1_we, b1.ram2_en, b1.ram2_oe, b1.ram2_we, b1.uart_rdn, b1.uart_wrn};
  endfunction
  function automatic logic [7:0] stb3();
    return {b3.ram1_en, b3.ram1_oe, b3.ram1_we, b3.ram2_en, b3.ram2_oe, b3.ram2_we, b3.uart_rdn, b3.uart_wrn};
  endfunction

  task automatic test_reset;
    #1;
    vec++; if (stb1() !== 8'hFF) begin err++; $display("FAIL reset_stb1 got %h exp ff", stb1()); end
    vec++; if (stb3() !== 8'hFF) begin err++; $display("FAIL reset_stb3 got %h exp ff", stb3()); end
    vec++; if ({b1.ram1_doe, b1.ram2_doe, b1.done_o, b1.busy_o} !== 4'b0000) begin err++; $display("FAIL reset_ctl1 got %b exp 0000", {b1.ram1_doe, b1.ram2_doe, b1.done_o, b1.busy_o}); end
    vec++; if (b1.rdata_o !== 16'h0000) begin err++; $display("FAIL reset_rdata got %h exp 0000", b1.rdata_o); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_w1;
    b1.addr_i = 16'h1234; b1.ram2_din = 16'hABCD; b1.mem_read_i = 1'b1; #1;
    for (int c = 0; c <= 3; c++) begin
      if (c > 0) @(negedge clk);
      vec++; if (b1.ram2_en !== ((c == 1 || c == 2) ? 1'b0 : 1'b1)) begin err++; $display("FAIL rd_w1_ram2_en c%0d got %b", c, b1.ram2_en); end
      vec++; if (b1.ram2_oe !== ((c == 2) ? 1'b0 : 1'b1)) begin err++; $display("FAIL rd_w1_ram2_oe c%0d got %b", c, b1.ram2_oe); end
      vec++; if (b1.done_o !== (c == 3)) begin err++; $display("FAIL rd_w1_done c%0d got %b", c, b1.done_o); end
      vec++; if (b1.busy_o !== (c <= 2)) begin err++; $display("FAIL rd_w1_busy c%0d got %b", c, b1.busy_o); end
      vec++; if ({b1.ram1_en, b1.ram2_doe} !== 2'b10) begin err++; $display("FAIL rd_w1_other c%0d got %b exp 10", c, {b1.ram1_en, b1.ram2_doe}); end
    end
    vec++; if (b1.rdata_o !== 16'hABCD) begin err++; $display("FAIL rd_w1_rdata got %h exp abcd", b1.rdata_o); end
    vec++; if (b1.ram2_addr !== 16'h1234) begin err++; $display("FAIL rd_w1_addr got %h exp 1234", b1.ram2_addr); end
    b1.mem_read_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_w3;
    b3.addr_i = 16'hC000; b3.wdata_i = 16'h5A5A; b3.mem_write_i = 1'b1; #1;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) @(negedge clk);
      vec++; if (b3.ram1_we !== ((c >= 2 && c <= 4) ? 1'b0 : 1'b1)) begin err++; $display("FAIL wr_w3_we c%0d got %b", c, b3.ram1_we); end
      vec++; if (b3.ram1_doe !== (c >= 1 && c <= 4)) begin err++; $display("FAIL wr_w3_doe c%0d got %b", c, b3.ram1_doe); end
      vec++; if ({b3.ram2_en, b3.ram2_oe, b3.ram2_we, b3.ram1_oe} !== 4'hF) begin err++; $display("FAIL wr_w3_idle c%0d got %b exp 1111", c, {b3.ram2_en, b3.ram2_oe, b3.ram2_we, b3.ram1_oe}); end
      vec++; if (b3.done_o !== (c == 5)) begin err++; $display("FAIL wr_w3_done c%0d got %b", c, b3.done_o); end
      if (c == 1) begin
        vec++; if (b3.ram1_dout !== 16'h5A5A) begin err++; $display("FAIL wr_w3_dout got %h exp 5a5a", b3.ram1_dout); end
        vec++; if (b3.ram1_addr !== 16'hC000) begin err++; $display("FAIL wr_w3_addr got %h exp c000", b3.ram1_addr); end
      end
    end
    b3.mem_write_i = 1'b0;
    @(negedge clk);
  endtask

  // Cycle-2 vector: {ram2_en, ram2_oe&we, ram1_en, ram1_oe&we, uart_rdn&wrn, ram1_doe}
  task automatic test_decode;
    logic [15:0] ad [5];
    logic        wr [5];
    logic [5:0]  es [5];
    logic [15:0] er [5];
    logic [5:0]  obs;
    ad[0] = 16'hBEFF; wr[0] = 1'b0; es[0] = 6'b001110; er[0] = 16'h2222;
    ad[1] = 16'hBF00; wr[1] = 1'b0; es[1] = 6'b111100; er[1] = 16'h1101;
    ad[2] = 16'hBF02; wr[2] = 1'b0; es[2] = 6'b110010; er[2] = 16'h1102;
    ad[3] = 16'hFFFF; wr[3] = 1'b0; es[3] = 6'b110010; er[3] = 16'h1103;
    ad[4] = 16'hBF00; wr[4] = 1'b1; es[4] = 6'b111101; er[4] = 16'h1103;
    b1.ram2_din = 16'h2222;
    for (int i = 0; i < 5; i++) begin
      b1.addr_i = ad[i]; b1.ram1_din = 16'h1100 + 16'(i); b1.wdata_i = 16'h00C3;
      b1.mem_read_i = !wr[i]; b1.mem_write_i = wr[i];
      @(negedge clk); @(negedge clk);
      obs = {b1.ram2_en, b1.ram2_oe & b1.ram2_we, b1.ram1_en, b1.ram1_oe & b1.ram1_we, b1.uart_rdn & b1.uart_wrn, b1.ram1_doe};
      vec++; if (obs !== es[i]) begin err++; $display("FAIL decode_%h strobes got %b exp %b", ad[i], obs, es[i]); end
      @(negedge clk);
      vec++; if ({b1.done_o, stb1()} !== 9'h1FF) begin err++; $display("FAIL decode_%h done got %b exp 111111111", ad[i], {b1.done_o, stb1()}); end
      vec++; if (b1.rdata_o !== er[i]) begin err++; $display("FAIL decode_%h rdata got %h exp %h", ad[i], b1.rdata_o, er[i]); end
      b1.mem_read_i = 1'b0; b1.mem_write_i = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_status;
    b1.uart_data_ready = 1'b1; b1.uart_tbre = 1'b1; b1.uart_tsre = 1'b0;
    b1.addr_i = 16'hBF01; b1.mem_read_i = 1'b1; #1;
    vec++; if ({b1.busy_o, b1.done_o, stb1()} !== 10'b10_1111_1111) begin err++; $display("FAIL stat_rd c0 got %b", {b1.busy_o, b1.done_o, stb1()}); end
    @(negedge clk);
    vec++; if ({b1.busy_o, b1.done_o, stb1(), b1.ram1_doe} !== 11'b01_1111_1111_0) begin err++; $display("FAIL stat_rd c1 got %b", {b1.busy_o, b1.done_o, stb1(), b1.ram1_doe}); end
    vec++; if (b1.rdata_o !== 16'h0002) begin err++; $display("FAIL stat_rd_rdata got %h exp 0002", b1.rdata_o); end
    b1.mem_read_i = 1'b0;
    @(negedge clk);
    // Status write is dropped: done next cycle, no strobes, rdata untouched.
    b1.uart_tsre = 1'b1; b1.mem_write_i = 1'b1; b1.wdata_i = 16'hFFFF;
    @(negedge clk);
    vec++; if ({b1.done_o, stb1(), b1.ram1_doe} !== 10'b1_1111_1111_0) begin err++; $display("FAIL stat_wr c1 got %b", {b1.done_o, stb1(), b1.ram1_doe}); end
    vec++; if (b1.rdata_o !== 16'h0002) begin err++; $display("FAIL stat_wr_rdata got %h exp 0002", b1.rdata_o); end
    b1.mem_write_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_both_set;
    b1.addr_i = 16'h0010; b1.ram2_din = 16'h4242; b1.mem_read_i = 1'b1; b1.mem_write_i = 1'b1; #1;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      vec++; if ({b1.busy_o, b1.done_o, stb1()} !== 10'b00_1111_1111) begin err++; $display("FAIL both_set c%0d got %b", c, {b1.busy_o, b1.done_o, stb1()}); end
    end
    b1.mem_write_i = 1'b0; #1;
    vec++; if (b1.busy_o !== 1'b1) begin err++; $display("FAIL both_then_rd busy got %b exp 1", b1.busy_o); end
    @(negedge clk); @(negedge clk);
    vec++; if (b1.ram2_oe !== 1'b0) begin err++; $display("FAIL both_then_rd oe got %b exp 0", b1.ram2_oe); end
    @(negedge clk);
    vec++; if ({b1.done_o, b1.rdata_o} !== {1'b1, 16'h4242}) begin err++; $display("FAIL both_then_rd done/rdata got %b/%h exp 1/4242", b1.done_o, b1.rdata_o); end
    b1.mem_read_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    b3.addr_i = 16'hC000; b3.wdata_i = 16'h1357; b3.mem_write_i = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    vec++; if ({b3.ram1_we, b3.ram1_doe} !== 2'b01) begin err++; $display("FAIL rstmid_pre got %b exp 01", {b3.ram1_we, b3.ram1_doe}); end
    rst = 1'b1; b3.mem_write_i = 1'b0; #1;
    vec++; if (stb3() !== 8'hFF) begin err++; $display("FAIL rstmid_stb got %h exp ff", stb3()); end
    vec++; if ({b3.ram1_doe, b3.done_o, b3.busy_o} !== 3'b000) begin err++; $display("FAIL rstmid_ctl got %b exp 000", {b3.ram1_doe, b3.done_o, b3.busy_o}); end
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      vec++; if ({b3.done_o, b3.busy_o, stb3()} !== 10'b00_1111_1111) begin err++; $display("FAIL rstmid_quiet c%0d got %b", c, {b3.done_o, b3.busy_o, stb3()}); end
    end
    b3.ram1_din = 16'h7777; b3.mem_read_i = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      vec++; if (b3.ram1_oe !== ((c >= 2 && c <= 4) ? 1'b0 : 1'b1)) begin err++; $display("FAIL rstmid_rd_oe c%0d got %b", c, b3.ram1_oe); end
    end
    vec++; if ({b3.done_o, b3.rdata_o} !== {1'b1, 16'h7777}) begin err++; $display("FAIL rstmid_rd done/rdata got %b/%h exp 1/7777", b3.done_o, b3.rdata_o); end
    b3.mem_read_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    {b1.mem_read_i, b1.mem_write_i, b3.mem_read_i, b3.mem_write_i} = '0;
    {b1.addr_i, b1.wdata_i, b1.ram1_din, b1.ram2_din} = '0;
    {b3.addr_i, b3.wdata_i, b3.ram1_din, b3.ram2_din} = '0;
    {b1.uart_data_ready, b1.uart_tbre, b1.uart_tsre} = '0;
    {b3.uart_data_ready, b3.uart_tbre, b3.uart_tsre} = '0;
    test_reset();
    test_read_w1();
    test_write_w3();
    test_decode();
    test_status();
    test_both_set();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout vectors=%0d", vec);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Parametrised successor to the combinational MEM-stage enable decoder.
- Decodes the ALU-computed address to RAM2 (low space), the UART data/status registers, or RAM1 (high space).
- Runs a multi-cycle SRAM/UART strobe sequence and stalls the pipeline via busy_o until the access completes.
- Sits between the EX/MEM register and the board-level SRAM/UART pins; the top level owns the tristate buffers.

Parameters:
- DATA_W, 16, data bus width.
- ADDR_W, 16, address width (CPU side and both SRAM address outputs).
- RAM2_TOP, 16'hBEFF, highest address mapped to RAM2.
- UART_DATA_ADDR, 16'hBF00, UART data register address.
- UART_STAT_ADDR, 16'hBF01, UART status register address (read-only).
- WAIT_CYC, 1, strobe-low cycles per access; legal range 1..7.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- mem_read_i  in  1  load request from EX/MEM.
- mem_write_i  in  1  store request from EX/MEM.
- addr_i  in  ADDR_W  access address (ALU result).
- wdata_i  in  DATA_W  store data.
- rdata_o  out  DATA_W  load result; held until the next load completes.
- busy_o  out  1  pipeline stall request.
- done_o  out  1  one-cycle completion pulse.
- ram1_en / ram1_oe / ram1_we  out  1 each  RAM1 strobes, active-low.
- ram1_addr  out  ADDR_W  RAM1 address.
- ram1_dout  out  DATA_W  RAM1/UART shared-bus write data.
- ram1_doe  out  1  RAM1/UART shared-bus drive enable.
- ram1_din  in  DATA_W  RAM1/UART shared-bus read data.
- ram2_en / ram2_oe / ram2_we  out  1 each  RAM2 strobes, active-low.
- ram2_addr  out  ADDR_W  RAM2 address.
- ram2_dout  out  DATA_W  RAM2 write data.
- ram2_doe  out  1  RAM2 drive enable.
- ram2_din  in  DATA_W  RAM2 read data.
- uart_rdn / uart_wrn  out  1 each  UART strobes, active-low.
- uart_data_ready, uart_tbre, uart_tsre  in  1 each  UART status inputs.

Behaviour:
- Reset (async, immediate):
  - All active-low strobes go to 1: ram1_en/oe/we, ram2_en/oe/we, uart_rdn/wrn.
  - ram1_doe = ram2_doe = 0; rdata_o = 0; done_o = 0; state = IDLE.
  - Reset mid-access aborts the access; no done_o pulse is produced.
- Target decode, evaluated in IDLE and latched on accept together with addr/wdata/direction:
  - addr <= RAM2_TOP selects RAM2.
  - addr == UART_DATA_ADDR selects the UART data register.
  - addr == UART_STAT_ADDR selects the UART status register.
  - All other addresses select RAM1.
  - Comparisons are unsigned and ADDR_W wide.
- Request acceptance:
  - Accepted only in IDLE, when exactly one of mem_read_i/mem_write_i is 1.
  - Both set, or neither set: no access; busy_o = 0; state stays IDLE.
  - Input changes while not IDLE are ignored; the pipeline holds its inputs while stalled.
- busy_o = (IDLE and valid request) or (state in SETUP/STROBE). It is 0 in DONE, so the pipeline advances in the same cycle as done_o.
- FSM:
  - IDLE -> SETUP on accept; status reads go IDLE -> DONE instead.
  - SETUP (1 cycle):
    - Selected chip's en = 0 (RAM1 or RAM2; UART accesses keep ram1_en = 1 on the shared bus).
    - Address driven.
    - For writes, doe = 1 and dout = latched wdata.
  - STROBE (WAIT_CYC cycles, 3-bit counter):
    - Read: oe = 0 (RAM) or uart_rdn = 0.
    - Write: we = 0 (RAM) or uart_wrn = 0.
    - Read data is sampled into rdata_o at the clock edge ending the last STROBE cycle.
  - DONE (1 cycle):
    - Strobes and en return high; doe = 0; done_o = 1.
    - Next state is IDLE.
- Latency: a RAM/UART-data access takes WAIT_CYC+2 cycles from accept to done_o.
- Status read:
  - Takes 1 cycle to DONE; no strobes toggle.
  - rdata_o = {zeros, uart_data_ready, uart_tbre & uart_tsre}, with data_ready in bit 1 and tbre&tsre in bit 0.
- Write to UART_STAT_ADDR: completes through DONE with no strobes or bus drive (silently dropped).
- Drive enable: doe is never 1 in the same cycle as that bus's oe = 0 or uart_rdn = 0.
- Idle address outputs: ram1_addr/ram2_addr keep their last value.
- rdata_o: updated only by completed reads.

Test Plan:
- Reset mid-STROBE of a RAM1 write at 16'hC000 -> all strobes high the same cycle, ram1_doe = 0, no done_o; a subsequent request is served normally.
- WAIT_CYC=1, read 16'h1234 with ram2_din = 16'hABCD -> ram2_en low for cycles 1–2, ram2_oe low in cycle 2, done_o in cycle 3, rdata_o = 16'hABCD, busy_o high for cycles 0–2.
- WAIT_CYC=3, write 16'h5A5A to 16'hC000 -> ram1_we low for exactly 3 cycles, ram1_doe = 1 from SETUP through the last STROBE cycle, ram2 strobes stay high, done_o at cycle 5.
- Boundary decode:
  - 16'hBEFF -> RAM2.
  - 16'hBF00 -> uart_wrn/uart_rdn pulse with ram1_en high.
  - 16'hBF02 -> RAM1.
  - 16'hFFFF -> RAM1.
- Status read at 16'hBF01 with data_ready=1, tbre=1, tsre=0 -> rdata_o = 16'h0002, done_o one cycle after accept, no strobes.
- mem_read_i = mem_write_i = 1 -> busy_o = 0, no strobes; then a single read is accepted normally.
